wb_monitor: RTL and testbench
=============================

# wb_monitor

Parametrised, synthesisable Wishbone classic-cycle bus monitor that attaches passively to a master/slave link. Tracks each STB/CYC request through a small state machine, counts completed reads and writes, captures the last completed transfer and raises sticky protocol-error flags (ACK timeout, spurious ACK, master abort, request change mid-cycle, optional X-check). Sits beside the SPI/Wishbone testbench or in-system as a debug/status source; it never drives the bus.

## Interface
- AW, 8, address width
- DW, 8, data width
- TIMEOUT, 16, max consecutive request edges without ACK (≥2)
- CNT_W, 16, width of transfer counters
- CLK  in  1  clock, all sampling on posedge
- RST  in  1  reset; asynchronous, active-high
- ADR  in  AW  bus address
- DATA_O  in  DW  master write data
- DATA_I  in  DW  slave read data
- WE  in  1  write enable
- STB  in  1  strobe
- CYC  in  1  cycle
- ACK  in  1  slave acknowledge
- CLR  in  1  synchronous clear of flags and counters
- busy  out  1  state != IDLE
- wr_cnt  out  CNT_W  completed writes, saturating
- rd_cnt  out  CNT_W  completed reads, saturating
- last_adr  out  AW  address of last completed transfer
- last_data  out  DW  DATA_O (write) or DATA_I (read) of last completed transfer
- err_timeout, err_spur_ack, err_abort, err_chg, err_x  out  1 each  sticky error flags
- err_any  out  1  OR of all error flags (registered)

## Operation
- req = STB & CYC. All outputs registered; reset value 0 for every output, state IDLE, wait counter 0.
- IDLE: req&ACK → zero-wait completion, stay IDLE. req&!ACK → WAIT, latch ADR/WE/DATA_O, wait_cnt=1. ACK&!req → set err_spur_ack.
- WAIT: req&ACK → completion (check below), IDLE. req&!ACK → wait_cnt+1; when wait_cnt+1 == TIMEOUT set err_timeout, go HUNG. !req → set err_abort, IDLE (no count). ACK with !req in WAIT → err_abort only.
- In WAIT, on any edge with req, ADR or WE differing from latched values, or (write) DATA_O differing from latched data → set err_chg; transfer still completes normally.
- HUNG: stays until ACK (with req: leave to IDLE, no count, no spur error) or !req (IDLE, no abort error).
- Completion: WE=1 → wr_cnt+1, last_data=DATA_O; WE=0 → rd_cnt+1, last_data=DATA_I; last_adr=ADR. Counters saturate at all-ones.
- CLR: clears all err_* flags and both counters; last_adr/last_data and state untouched. Event in same cycle as CLR is applied after clear (flag=1 or counter=1).
- RST mid-transfer: immediate return to IDLE, all outputs 0; transfer in progress is not counted.

## Timing
- Every update visible the cycle after the sampling edge (1-cycle latency); err_any same cycle as the flag it reflects.
- Zero-wait transfer: one edge; N-wait: counted at the ACK edge.
- Timeout: with TIMEOUT=16, request edges 1..15 without ACK → WAIT; 16th edge sets err_timeout, busy stays 1 (HUNG).
- Back-to-back transfers (req held, ACK every edge) counted once per edge.

## Configuration
- WB_MON_XCHECK_EN defined: err_x sets on any edge with req&WE and X/Z on ADR or DATA_O, or req&!WE&ACK and X/Z on DATA_I or ADR; also enables concurrent assertions issuing $warning for each error flag condition. Simulation-only.
- Not defined: err_x tied 0, no assertions, block fully synthesisable.

## Test plan
- Zero-wait write ADR=0x12 DATA_O=0xA5 then 2-wait read returning 0x3C → wr_cnt=1, rd_cnt=1, last_adr/last_data=read's values, no errors.
- TIMEOUT=16, request held 20 edges without ACK then ACK → err_timeout set after edge 16, counts unchanged, busy drops after ACK.
- ACK pulse with CYC=0 → err_spur_ack=1, err_any=1; then CLR → all flags 0.
- WAIT state, ADR changes 0x10→0x11 before ACK → err_chg=1, transfer counted; STB dropped before ACK in next transfer → err_abort=1, not counted.
- Write with DATA_O=X: macro defined → err_x=1 plus warning; undefined → err_x=0. Assert RST mid-WAIT → all outputs 0 next cycle.

Source files
------------

// File: rtl/wb_monitor.sv
// Passive Wishbone classic-cycle monitor: transfer counters, last-transfer capture, sticky error flags.
// Define WB_MON_XCHECK_EN to enable the simulation-only X/Z check (err_x) and warning assertions.
module wb_monitor #(
   parameter int AW      = 8,
   parameter int DW      = 8,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [AW-1:0]    ADR,
   input  logic [DW-1:0]    DATA_O,
   input  logic [DW-1:0]    DATA_I,
   input  logic             WE,
   input  logic             STB,
   input  logic             CYC,
   input  logic             ACK,
   input  logic             CLR,
   output logic             busy,
   output logic [CNT_W-1:0] wr_cnt,
   output logic [CNT_W-1:0] rd_cnt,
   output logic [AW-1:0]    last_adr,
   output logic [DW-1:0]    last_data,
   output logic             err_timeout,
   output logic             err_spur_ack,
   output logic             err_abort,
   output logic             err_chg,
   output logic             err_x,
   output logic             err_any
);

   localparam int WCW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, WAIT, HUNG} state_t;

   state_t           state, state_n;
   logic [WCW-1:0]   wait_cnt, wait_cnt_n, wait_inc;
   logic [AW-1:0]    lat_adr;
   logic             lat_we;
   logic [DW-1:0]    lat_dat;

   logic             req;
   logic             done, latch;
   logic             to_set, spur_set, abort_set, chg_set, x_set;
   logic [4:0]       err_q, err_n;
   logic [CNT_W-1:0] wr_base, rd_base, wr_n, rd_n;

   assign req      = STB & CYC;
   assign wait_inc = wait_cnt + WCW'(1);

   always_comb begin
      state_n    = state;
      wait_cnt_n = wait_cnt;
      done       = 1'b0;
      latch      = 1'b0;
      to_set     = 1'b0;
      spur_set   = 1'b0;
      abort_set  = 1'b0;
      chg_set    = 1'b0;
      unique case (state)
         IDLE: begin
            if (req && ACK) begin
               done = 1'b1;
            end else if (req) begin
               state_n    = WAIT;
               wait_cnt_n = WCW'(1);
               latch      = 1'b1;
            end else if (ACK) begin
               spur_set = 1'b1;
            end
         end
         WAIT: begin
            if (req && (ADR != lat_adr || WE != lat_we ||
                        (lat_we && DATA_O != lat_dat)))
               chg_set = 1'b1;
            if (req && ACK) begin
               done       = 1'b1;
               state_n    = IDLE;
               wait_cnt_n = '0;
            end else if (req) begin
               wait_cnt_n = wait_inc;
               if (wait_inc == WCW'(TIMEOUT)) begin
                  to_set  = 1'b1;
                  state_n = HUNG;
               end
            end else begin
               abort_set  = 1'b1;
               state_n    = IDLE;
               wait_cnt_n = '0;
            end
         end
         HUNG: begin
            // A late ACK or a dropped request ends the hang silently
            if (!req || ACK) begin
               state_n    = IDLE;
               wait_cnt_n = '0;
            end
         end
         default: begin
            state_n    = IDLE;
            wait_cnt_n = '0;
         end
      endcase
   end

`ifdef WB_MON_XCHECK_EN
   assign x_set = (req && WE && ($isunknown(ADR) || $isunknown(DATA_O))) ||
                  (req && !WE && ACK && ($isunknown(DATA_I) || $isunknown(ADR)));

   a_timeout: assert property (@(posedge CLK) disable iff (RST) !to_set)
      else $warning("wb_monitor: ACK timeout");
   a_spur: assert property (@(posedge CLK) disable iff (RST) !spur_set)
      else $warning("wb_monitor: spurious ACK");
   a_abort: assert property (@(posedge CLK) disable iff (RST) !abort_set)
      else $warning("wb_monitor: master abort");
   a_chg: assert property (@(posedge CLK) disable iff (RST) !chg_set)
      else $warning("wb_monitor: request changed mid-cycle");
   a_x: assert property (@(posedge CLK) disable iff (RST) !x_set)
      else $warning("wb_monitor: X/Z on bus");
`else
   assign x_set = 1'b0;
`endif

   // Clear first, then this cycle's events, so a same-cycle event survives CLR
   assign err_q   = {err_x, err_chg, err_abort, err_spur_ack, err_timeout};
   assign err_n   = (CLR ? 5'b0 : err_q) |
                    {x_set, chg_set, abort_set, spur_set, to_set};
   assign wr_base = CLR ? '0 : wr_cnt;
   assign rd_base = CLR ? '0 : rd_cnt;
   assign wr_n    = (done && WE) ?
                    wr_base + {{(CNT_W-1){1'b0}}, ~&wr_base} : wr_base;
   assign rd_n    = (done && !WE) ?
                    rd_base + {{(CNT_W-1){1'b0}}, ~&rd_base} : rd_base;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state        <= IDLE;
         wait_cnt     <= '0;
         lat_adr      <= '0;
         lat_we       <= 1'b0;
         lat_dat      <= '0;
         busy         <= 1'b0;
         wr_cnt       <= '0;
         rd_cnt       <= '0;
         last_adr     <= '0;
         last_data    <= '0;
         err_timeout  <= 1'b0;
         err_spur_ack <= 1'b0;
         err_abort    <= 1'b0;
         err_chg      <= 1'b0;
         err_x        <= 1'b0;
         err_any      <= 1'b0;
      end else begin
         state    <= state_n;
         wait_cnt <= wait_cnt_n;
         busy     <= (state_n != IDLE);
         if (latch) begin
            lat_adr <= ADR;
            lat_we  <= WE;
            lat_dat <= DATA_O;
         end
         if (done) begin
            last_adr  <= ADR;
            last_data <= WE ? DATA_O : DATA_I;
         end
         wr_cnt       <= wr_n;
         rd_cnt       <= rd_n;
         err_timeout  <= err_n[0];
         err_spur_ack <= err_n[1];
         err_abort    <= err_n[2];
         err_chg      <= err_n[3];
         err_x        <= err_n[4];
         err_any      <= |err_n;
      end
   end

endmodule

// File: tb/tb_wb_monitor.sv
// Directed testbench for wb_monitor with default parameters.
module tb_wb_monitor;

   logic        CLK = 1'b0;
   logic        RST, WE, STB, CYC, ACK, CLR;
   logic [7:0]  ADR, DATA_O, DATA_I;
   logic        busy;
   logic [15:0] wr_cnt, rd_cnt;
   logic [7:0]  last_adr, last_data;
   logic        err_timeout, err_spur_ack, err_abort, err_chg, err_x, err_any;

   int n_cmp = 0;
   int n_bad = 0;

   wb_monitor dut (
      .CLK(CLK), .RST(RST), .ADR(ADR), .DATA_O(DATA_O), .DATA_I(DATA_I),
      .WE(WE), .STB(STB), .CYC(CYC), .ACK(ACK), .CLR(CLR),
      .busy(busy), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt),
      .last_adr(last_adr), .last_data(last_data),
      .err_timeout(err_timeout), .err_spur_ack(err_spur_ack),
      .err_abort(err_abort), .err_chg(err_chg), .err_x(err_x),
      .err_any(err_any)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic bus(input logic s, input logic c, input logic a,
                      input logic w, input logic [7:0] ad,
                      input logic [7:0] dwr, input logic [7:0] drd);
      STB = s; CYC = c; ACK = a; WE = w;
      ADR = ad; DATA_O = dwr; DATA_I = drd;
   endtask

   task automatic idle();
      bus(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
   endtask

   task automatic test_reset();
      RST = 1; CLR = 0; idle();
      step(); step();
      RST = 0;
      step();
      n_cmp++;
      if ({busy, wr_cnt, rd_cnt, last_adr, last_data} !== 49'd0) begin
         n_bad++;
         $display("FAIL reset_outputs got busy=%0d wr=%0d rd=%0d adr=%h dat=%h want all 0",
                  busy, wr_cnt, rd_cnt, last_adr, last_data);
      end
      n_cmp++;
      if ({err_timeout, err_spur_ack, err_abort, err_chg, err_x, err_any} !== 6'b0) begin
         n_bad++;
         $display("FAIL reset_flags got %b want 000000",
                  {err_timeout, err_spur_ack, err_abort, err_chg, err_x, err_any});
      end
   endtask

   task automatic test_basic();
      bus(1, 1, 1, 1, 8'h12, 8'hA5, 8'h00);
      step();
      n_cmp++;
      if ({busy, wr_cnt, last_adr, last_data} !== {1'b0, 16'd1, 8'h12, 8'hA5}) begin
         n_bad++;
         $display("FAIL zw_write got busy=%0d wr=%0d adr=%h dat=%h want 0 1 12 a5",
                  busy, wr_cnt, last_adr, last_data);
      end
      bus(1, 1, 0, 0, 8'h34, 8'h00, 8'h00);
      step(); step();
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL read_wait_busy got %0d want 1", busy);
      end
      bus(1, 1, 1, 0, 8'h34, 8'h00, 8'h3C);
      step();
      idle();
      n_cmp++;
      if ({busy, wr_cnt, rd_cnt, last_adr, last_data, err_any} !==
          {1'b0, 16'd1, 16'd1, 8'h34, 8'h3C, 1'b0}) begin
         n_bad++;
         $display("FAIL wait_read got busy=%0d wr=%0d rd=%0d adr=%h dat=%h any=%0d want 0 1 1 34 3c 0",
                  busy, wr_cnt, rd_cnt, last_adr, last_data, err_any);
      end
   endtask

   task automatic test_timeout();
      bus(1, 1, 0, 0, 8'h40, 8'h00, 8'h00);
      for (int i = 1; i <= 20; i++) begin
         step();
         if (i == 15) begin
            n_cmp++;
            if ({busy, err_timeout, err_any} !== 3'b100) begin
               n_bad++;
               $display("FAIL timeout_edge15 got busy/to/any=%b want 100",
                        {busy, err_timeout, err_any});
            end
         end
         if (i == 16) begin
            n_cmp++;
            if ({busy, err_timeout, err_any} !== 3'b111) begin
               n_bad++;
               $display("FAIL timeout_edge16 got busy/to/any=%b want 111",
                        {busy, err_timeout, err_any});
            end
         end
      end
      ACK = 1; DATA_I = 8'h77;
      step();
      idle();
      n_cmp++;
      if ({busy, wr_cnt, rd_cnt, last_adr, err_spur_ack, err_timeout} !==
          {1'b0, 16'd1, 16'd1, 8'h34, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL hung_release got busy=%0d wr=%0d rd=%0d adr=%h spur=%0d to=%0d want 0 1 1 34 0 1",
                  busy, wr_cnt, rd_cnt, last_adr, err_spur_ack, err_timeout);
      end
      CLR = 1;
      step();
      CLR = 0;
      n_cmp++;
      if ({wr_cnt, rd_cnt, err_timeout, err_any, last_adr} !== {32'd0, 2'b00, 8'h34}) begin
         n_bad++;
         $display("FAIL clr_after_to got wr=%0d rd=%0d to=%0d any=%0d adr=%h want 0 0 0 0 34",
                  wr_cnt, rd_cnt, err_timeout, err_any, last_adr);
      end
   endtask

   task automatic test_spur();
      bus(0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
      step();
      idle();
      n_cmp++;
      if ({err_spur_ack, err_any, busy} !== 3'b110) begin
         n_bad++;
         $display("FAIL spur_ack got spur/any/busy=%b want 110",
                  {err_spur_ack, err_any, busy});
      end
      CLR = 1;
      step();
      CLR = 0;
      n_cmp++;
      if ({err_timeout, err_spur_ack, err_abort, err_chg, err_x, err_any} !== 6'b0) begin
         n_bad++;
         $display("FAIL spur_clr got %b want 000000",
                  {err_timeout, err_spur_ack, err_abort, err_chg, err_x, err_any});
      end
   endtask

   task automatic test_chg_abort();
      bus(1, 1, 0, 1, 8'h10, 8'h55, 8'h00);
      step();
      ADR = 8'h11;
      step();
      n_cmp++;
      if ({err_chg, err_any, busy} !== 3'b111) begin
         n_bad++;
         $display("FAIL chg_flag got chg/any/busy=%b want 111", {err_chg, err_any, busy});
      end
      ACK = 1;
      step();
      n_cmp++;
      if ({wr_cnt, last_adr, last_data, busy} !== {16'd1, 8'h11, 8'h55, 1'b0}) begin
         n_bad++;
         $display("FAIL chg_counted got wr=%0d adr=%h dat=%h busy=%0d want 1 11 55 0",
                  wr_cnt, last_adr, last_data, busy);
      end
      bus(1, 1, 0, 0, 8'h20, 8'h00, 8'h00);
      step();
      STB = 0;
      step();
      idle();
      n_cmp++;
      if ({err_abort, busy, rd_cnt, wr_cnt, last_adr} !== {2'b10, 16'd0, 16'd1, 8'h11}) begin
         n_bad++;
         $display("FAIL abort got abort=%0d busy=%0d rd=%0d wr=%0d adr=%h want 1 0 0 1 11",
                  err_abort, busy, rd_cnt, wr_cnt, last_adr);
      end
   endtask

   task automatic test_clr_same_cycle();
      CLR = 1;
      bus(1, 1, 1, 1, 8'h66, 8'h99, 8'h00);
      step();
      n_cmp++;
      if ({wr_cnt, err_chg, err_abort, err_any} !== {16'd1, 3'b000}) begin
         n_bad++;
         $display("FAIL clr_with_write got wr=%0d chg=%0d abort=%0d any=%0d want 1 0 0 0",
                  wr_cnt, err_chg, err_abort, err_any);
      end
      bus(0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
      step();
      n_cmp++;
      if ({wr_cnt, err_spur_ack, err_any} !== {16'd0, 2'b11}) begin
         n_bad++;
         $display("FAIL clr_with_spur got wr=%0d spur=%0d any=%0d want 0 1 1",
                  wr_cnt, err_spur_ack, err_any);
      end
      idle();
      step();
      CLR = 0;
   endtask

   task automatic test_back_to_back();
      logic [7:0] d [3] = '{8'h01, 8'h02, 8'h03};
      for (int i = 0; i < 3; i++) begin
         bus(1, 1, 1, 1, 8'h80 + 8'(i), d[i], 8'h00);
         step();
         n_cmp++;
         if ({wr_cnt, last_adr, last_data, busy} !==
             {16'(i + 1), 8'h80 + 8'(i), d[i], 1'b0}) begin
            n_bad++;
            $display("FAIL b2b_%0d got wr=%0d adr=%h dat=%h busy=%0d want %0d %h %h 0",
                     i, wr_cnt, last_adr, last_data, busy, i + 1, 8'h80 + 8'(i), d[i]);
         end
      end
      idle();
   endtask

   task automatic test_xcheck();
      bus(1, 1, 1, 1, 8'h70, 8'hxx, 8'h00);
      step();
      idle();
      n_cmp++;
      if (wr_cnt !== 16'd4) begin
         n_bad++;
         $display("FAIL x_write_cnt got %0d want 4", wr_cnt);
      end
`ifndef WB_MON_XCHECK_EN
      n_cmp++;
      if ({err_x, err_any} !== 2'b00) begin
         n_bad++;
         $display("FAIL x_disabled got x/any=%b want 00", {err_x, err_any});
      end
`endif
   endtask

   task automatic test_rst_mid();
      bus(1, 1, 0, 0, 8'h50, 8'h00, 8'h00);
      step();
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL pre_rst_busy got %0d want 1", busy);
      end
      #2 RST = 1;
      #1;
      n_cmp++;
      if ({busy, wr_cnt, rd_cnt, last_adr, last_data} !== 49'd0) begin
         n_bad++;
         $display("FAIL rst_async got busy=%0d wr=%0d rd=%0d adr=%h dat=%h want all 0",
                  busy, wr_cnt, rd_cnt, last_adr, last_data);
      end
      ACK = 1;
      step();
      RST = 0;
      idle();
      step();
      n_cmp++;
      if ({busy, rd_cnt, err_any, err_spur_ack} !== {1'b0, 16'd0, 2'b00}) begin
         n_bad++;
         $display("FAIL rst_mid_after got busy=%0d rd=%0d any=%0d spur=%0d want 0 0 0 0",
                  busy, rd_cnt, err_any, err_spur_ack);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_timeout();
      test_spur();
      test_chg_abort();
      test_clr_same_cycle();
      test_back_to_back();
      test_xcheck();
      test_rst_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
